uart_tx_arbiter: RTL and testbench

//  Shares one native-FIFO-style UART transmitter among NUM_PORTS requester FIFOs.

---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the per-requester FIFO read ports and the shared transmitter read port.
// master = arbiter side, slave = requester FIFOs plus transmitter side.
interface uart_tx_arbiter_if #(
    parameter int NUM_PORTS  = 4,
    parameter int WORD_WIDTH = 8
);
    logic [NUM_PORTS-1:0]            req_empty;
    logic [NUM_PORTS*WORD_WIDTH-1:0] req_data;
    logic [NUM_PORTS-1:0]            req_re;
    logic [WORD_WIDTH-1:0]           tx_data;
    logic                            tx_empty;
    logic                            tx_re;
    logic [NUM_PORTS-1:0]            grant;
    logic                            busy;

    modport master (
        input  req_empty, req_data, tx_re,
        output req_re, tx_data, tx_empty, grant, busy
    );

    modport slave (
        output req_empty, req_data, tx_re,
        input  req_re, tx_data, tx_empty, grant, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, burst-limited sharing of one native-FIFO UART transmitter among NUM_PORTS FIFOs.
// Optional UART_ARB_TAG_EN: each grant is preceded by a tag word TAG_BASE | owner index.
//
// state  | meaning
// IDLE   | no owner; picks next non-empty port from rr_ptr, offers nothing
// TAG    | (UART_ARB_TAG_EN only) offering the owner's tag word
// STREAM | owner's FIFO head routed to the transmitter until burst limit or empty
module uart_tx_arbiter #(
    parameter int                    NUM_PORTS  = 4,
    parameter int                    WORD_WIDTH = 8,
    parameter int                    MAX_BURST  = 4,
    parameter logic [WORD_WIDTH-1:0] TAG_BASE   = 'hF0
) (
    input logic               clk,
    input logic               rst,
    uart_tx_arbiter_if.master bus
);
    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] LAST = BW'(MAX_BURST - 1);
    localparam logic [IW-1:0] TOP  = IW'(NUM_PORTS - 1);

    if (NUM_PORTS < 2 || MAX_BURST < 1 || $bits(TAG_BASE) != WORD_WIDTH) begin : g_bad_cfg
        $error("uart_tx_arbiter: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE,
`ifdef UART_ARB_TAG_EN
        S_TAG,
`endif
        S_STREAM
    } state_t;

    state_t                  state, state_nx;
    logic [IW-1:0]           owner, owner_nx;
    logic [IW-1:0]           rr_ptr, rr_nx;
    logic [BW-1:0]           burst_cnt, burst_nx;
    logic [NUM_PORTS-1:0]    grant_q, grant_nx;
    logic                    sel_found;
    logic [IW-1:0]           sel_idx;
    logic                    owner_empty;
    logic [WORD_WIDTH-1:0]   owner_data;
    logic                    accept;
    logic [NUM_PORTS-1:0]    req_re;
    logic [WORD_WIDTH-1:0]   tx_data;
    logic                    tx_empty;

    // Scan from the farthest offset down so the port closest to rr_ptr wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = rr_ptr;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (!bus.req_empty[(int'(rr_ptr) + k) % NUM_PORTS]) begin
                sel_found = 1'b1;
                sel_idx   = IW'((int'(rr_ptr) + k) % NUM_PORTS);
            end
        end
    end

    assign owner_empty = bus.req_empty[owner];
    assign owner_data  = bus.req_data[int'(owner)*WORD_WIDTH +: WORD_WIDTH];

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        rr_nx    = rr_ptr;
        burst_nx = burst_cnt;
        tx_data  = '0;
        tx_empty = 1'b1;
        req_re   = '0;
        accept   = 1'b0;
        case (state)
            S_IDLE: begin
                burst_nx = '0;
                if (sel_found) begin
                    owner_nx = sel_idx;
`ifdef UART_ARB_TAG_EN
                    state_nx = S_TAG;
`else
                    state_nx = S_STREAM;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            S_TAG: begin
                tx_data  = TAG_BASE | WORD_WIDTH'(owner);
                tx_empty = 1'b0;
                if (bus.tx_re) state_nx = S_STREAM;
            end
`endif
            S_STREAM: begin
                tx_data       = owner_data;
                tx_empty      = owner_empty;
                accept        = bus.tx_re & ~owner_empty;
                req_re[owner] = accept;
                if (accept) burst_nx = burst_cnt + BW'(1);
                // Burst limit hit, or owner ran dry: hand over, owner gets lowest priority.
                if ((accept && burst_cnt == LAST) || owner_empty) begin
                    state_nx = S_IDLE;
                    rr_nx    = (owner == TOP) ? '0 : owner + IW'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        grant_nx = '0;
        if (state_nx != S_IDLE) grant_nx[owner_nx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            grant_q   <= '0;
        end else begin
            state     <= state_nx;
            owner     <= owner_nx;
            rr_ptr    <= rr_nx;
            burst_cnt <= burst_nx;
            grant_q   <= grant_nx;
        end
    end

    assign bus.req_re   = req_re;
    assign bus.tx_data  = tx_data;
    assign bus.tx_empty = tx_empty;
    assign bus.grant    = grant_q;
    assign bus.busy     = (state != S_IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: modelled requester FIFOs, expected words queued at stimulus time.
// Builds with or without UART_ARB_TAG_EN; tag words are expected only when it is defined.
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int W = 8;
`ifdef UART_ARB_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] port;
        logic [7:0] data;
        logic       tag;
    } sb_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_PORTS(N), .WORD_WIDTH(W)) bus ();

    uart_tx_arbiter #(
        .NUM_PORTS (N),
        .WORD_WIDTH(W),
        .MAX_BURST (4),
        .TAG_BASE  (8'hF0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    logic [7:0] fifo [N][$];
    sb_t        exp_q[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    int         p1_pulses = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            bus.req_empty[i]       = (fifo[i].size() == 0);
            bus.req_data[i*W +: W] = (fifo[i].size() != 0) ? fifo[i][0] : 8'h00;
        end
    endtask

    // Monitor: sample at negedge, apply FIFO pops just after the edge that took them.
    initial begin
        logic [N-1:0] pop_mask;
        logic [N-1:0] prev_grant;
        sb_t          e;
        prev_grant = '0;
        refresh();
        forever begin
            @(negedge clk);
            if (bus.tx_re && !bus.tx_empty) begin
                chk_eq("exp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk_eq("tx_data", 32'(bus.tx_data), 32'(e.data));
                    chk_eq("grant_xfer", 32'(bus.grant), 32'(1) << e.port);
                    chk_eq("req_re_xfer", 32'(bus.req_re), e.tag ? 32'd0 : (32'(1) << e.port));
                end
            end else begin
                chk_eq("req_re_noxfer", 32'(bus.req_re), 32'd0);
            end
            if (bus.grant != '0 && prev_grant != '0)
                chk_eq("grant_hold", 32'(bus.grant), 32'(prev_grant));
            prev_grant = bus.grant;
            if (bus.req_re[1]) p1_pulses++;
            pop_mask = bus.req_re;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++)
                if (pop_mask[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
            #1;
            refresh();
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int p, input logic [7:0] d);
        fifo[p].push_back(d);
    endtask

    task automatic exp_word(input int p, input logic [7:0] d);
        exp_q.push_back('{port: 2'(p), data: d, tag: 1'b0});
    endtask

    task automatic exp_tag(input int p);
        if (TAG_EN) exp_q.push_back('{port: 2'(p), data: 8'hF0 | 8'(p), tag: 1'b1});
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cyc(1);
            n++;
        end
        chk_eq(tag, 32'(exp_q.size()), 32'd0);
        cyc(3);
    endtask

    task automatic wait_grant(input string tag, input logic [N-1:0] mask, input int budget);
        int n = 0;
        while (bus.grant != mask && n < budget) begin
            cyc(1);
            n++;
        end
        chk_eq(tag, 32'(bus.grant), 32'(mask));
    endtask

    initial begin
        int base;
        rst = 1'b1;
        bus.tx_re = 1'b0;
        cyc(3);
        @(negedge clk);
        chk_eq("rst_grant", 32'(bus.grant), 32'd0);
        chk_eq("rst_tx_empty", 32'(bus.tx_empty), 32'd1);
        chk_eq("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk_eq("rst_busy", 32'(bus.busy), 32'd0);
        chk_eq("rst_req_re", 32'(bus.req_re), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(2);

        // single requester, registered grant latency
        bus.tx_re = 1'b1;
        push(2, 8'hA5); push(2, 8'h5A); push(2, 8'hC3);
        exp_tag(2); exp_word(2, 8'hA5); exp_word(2, 8'h5A); exp_word(2, 8'hC3);
        @(negedge clk);
        chk_eq("t2_grant_pre", 32'(bus.grant), 32'd0);
        @(negedge clk);
        chk_eq("t2_grant", 32'(bus.grant), 32'b0100);
        @(posedge clk);
        #1;
        wait_drain("t2_drain", 40);
        @(negedge clk);
        chk_eq("t2_busy_after", 32'(bus.busy), 32'd0);
        chk_eq("t2_grant_after", 32'(bus.grant), 32'd0);
        @(posedge clk);
        #1;

        // two requesters, burst limit alternation
        for (int i = 0; i < 6; i++) begin
            push(0, 8'h10 + 8'(i));
            push(1, 8'h20 + 8'(i));
        end
        exp_tag(0); for (int i = 0; i < 4; i++) exp_word(0, 8'h10 + 8'(i));
        exp_tag(1); for (int i = 0; i < 4; i++) exp_word(1, 8'h20 + 8'(i));
        exp_tag(0); for (int i = 4; i < 6; i++) exp_word(0, 8'h10 + 8'(i));
        exp_tag(1); for (int i = 4; i < 6; i++) exp_word(1, 8'h20 + 8'(i));
        wait_drain("t3_drain", 100);

        // port 3 served, then pointer wraps to port 0
        push(3, 8'h33);
        exp_tag(3); exp_word(3, 8'h33);
        wait_drain("t4a_drain", 40);
        push(0, 8'h40); push(3, 8'h43);
        exp_tag(0); exp_word(0, 8'h40);
        exp_tag(3); exp_word(3, 8'h43);
        wait_drain("t4b_drain", 40);

        // stalled transmitter holds the grant
        bus.tx_re = 1'b0;
        push(1, 8'h51); push(1, 8'h52);
        exp_tag(1); exp_word(1, 8'h51); exp_word(1, 8'h52);
        wait_grant("t5_grant", 4'b0010, 10);
        repeat (50) begin
            @(negedge clk);
            chk_eq("t5_tx_data", 32'(bus.tx_data), TAG_EN ? 32'hF1 : 32'h51);
            chk_eq("t5_grant_hold", 32'(bus.grant), 32'b0010);
            chk_eq("t5_req_re", 32'(bus.req_re), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.tx_re = 1'b1;
        wait_drain("t5_drain", 40);

        // single word, read strobe pulses once
        base = p1_pulses;
        push(1, 8'h11);
        exp_tag(1); exp_word(1, 8'h11);
        wait_drain("t6_drain", 40);
        chk_eq("t6_re_pulses", 32'(p1_pulses - base), 32'd1);

        // reset mid-grant, then lowest non-empty index wins
        bus.tx_re = 1'b0;
        push(2, 8'h61); push(2, 8'h62);
        wait_grant("t1_grant_p2", 4'b0100, 10);
        rst = 1'b1;
        push(1, 8'h71);
        cyc(1);
        @(negedge clk);
        chk_eq("t1_grant", 32'(bus.grant), 32'd0);
        chk_eq("t1_tx_empty", 32'(bus.tx_empty), 32'd1);
        chk_eq("t1_req_re", 32'(bus.req_re), 32'd0);
        chk_eq("t1_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.tx_re = 1'b1;
        exp_tag(1); exp_word(1, 8'h71);
        exp_tag(2); exp_word(2, 8'h61); exp_word(2, 8'h62);
        @(negedge clk);
        @(negedge clk);
        chk_eq("t1_regrant", 32'(bus.grant), 32'b0010);
        @(posedge clk);
        #1;
        wait_drain("t1_drain", 40);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
